// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if -- byte-level SPI shifter side plus register-bus side of
// the SPI command decoder, bundled for a single port connection.
//
//   slave  modport : the decoder (spi_reg_ctrl) view
//   master modport : the surrounding environment (shifter + register file)
//
// Signals:
//   spi_rx_data/first/valid  received byte, frame-start flag, byte strobe
//   spi_tx_data/load         next byte for the shifter and its load strobe
//   reg_wr_addr/data/en      register write request
//   reg_rd_addr/en           register read request
//   reg_rd_data/valid        register read response
//   err_underrun             read data was not ready in time
//   busy                     decoder is in the middle of a transaction
interface spi_reg_ctrl_if #(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 4
);
  localparam int ADDR_W = 4 + 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;

  logic [7:0]        spi_rx_data;
  logic              spi_rx_first;
  logic              spi_rx_valid;
  logic [7:0]        spi_tx_data;
  logic              spi_tx_load;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_rd_addr;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_valid;
  logic              err_underrun;
  logic              busy;

  modport slave (
    input  spi_rx_data, spi_rx_first, spi_rx_valid, reg_rd_data, reg_rd_valid,
    output spi_tx_data, spi_tx_load, reg_wr_addr, reg_wr_data, reg_wr_en,
           reg_rd_addr, reg_rd_en, err_underrun, busy
  );

  modport master (
    output spi_rx_data, spi_rx_first, spi_rx_valid, reg_rd_data, reg_rd_valid,
    input  spi_tx_data, spi_tx_load, reg_wr_addr, reg_wr_data, reg_wr_en,
           reg_rd_addr, reg_rd_en, err_underrun, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl -- SPI-slave command decoder between a byte-level SPI shifter
// and a single-outstanding register bus.
//
// Frame: command byte (op in [7:4], address MSBs in [3:0]), ADDR_BYTES
// address bytes MSB first, then either DATA_BYTES write bytes MSB first, or
// (for reads) one turnaround byte after which the read word is returned
// MSB first, one byte per rx strobe.
//   op 0x0 single read, 0x1 single write, 0x2 burst read, 0x3 burst write.
//
// Build option: define SPI_REG_CTRL_BURST_EN to enable the burst ops 0x2/0x3
// (auto-incrementing address, wraps modulo 2^ADDR_W). Without it those ops
// are treated as invalid and no increment logic exists.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    spi_reg_ctrl_if.slave (SPI byte side + register bus side)
module spi_reg_ctrl #(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 4
) (
  input logic           clk,
  input logic           rst_n,
  spi_reg_ctrl_if.slave bus
);
  localparam int ADDR_W = 4 + 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DISCARD
  } state_t;

  state_t state, state_d;

  logic              cmd_stb, dat_stb, op_ok;
  logic [ADDR_W-1:0] addr, addr_d, addr_shift;
  logic [DATA_W-1:0] wsh, wsh_d, data_shift;
  logic [DATA_W-1:0] rsh, rsh_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              is_wr, is_wr_d;
`ifdef SPI_REG_CTRL_BURST_EN
  logic              burst, burst_d;
`endif

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic              tx_load_q, tx_load_d, err_q, err_d;

  // A first-of-frame byte is a command regardless of state; it overrides
  // every other event in the same cycle, including reg_rd_valid.
  assign cmd_stb = bus.spi_rx_valid & bus.spi_rx_first;
  assign dat_stb = bus.spi_rx_valid & ~bus.spi_rx_first;

  assign addr_shift = {addr[ADDR_W-9:0], bus.spi_rx_data};
  assign data_shift = DATA_W'(wsh << 8) | DATA_W'(bus.spi_rx_data);

  always_comb begin : op_decode
    op_ok = 1'b0;
    case (bus.spi_rx_data[7:4])
      4'h0, 4'h1: op_ok = 1'b1;
`ifdef SPI_REG_CTRL_BURST_EN
      4'h2, 4'h3: op_ok = 1'b1;
`endif
      default:    op_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin : next_state
    state_d = state;
    if (cmd_stb) begin
      state_d = op_ok ? S_ADDR : S_DISCARD;
    end else begin
      case (state)
        S_ADDR:
          if (dat_stb && cnt == ADDR_LAST) state_d = is_wr ? S_WDATA : S_RWAIT;
        S_WDATA:
          if (dat_stb && cnt == DATA_LAST) begin
`ifdef SPI_REG_CTRL_BURST_EN
            state_d = burst ? S_WDATA : S_DISCARD;
`else
            state_d = S_DISCARD;
`endif
          end
        S_RWAIT:
          if (dat_stb)               state_d = S_DISCARD;
          else if (bus.reg_rd_valid) state_d = S_RDATA;
        S_RDATA:
          if (dat_stb && cnt == DATA_END) begin
`ifdef SPI_REG_CTRL_BURST_EN
            state_d = burst ? S_RWAIT : S_DISCARD;
`else
            state_d = S_DISCARD;
`endif
          end
        default: state_d = state;
      endcase
    end
  end

  // Output and datapath next values. Every strobe output is registered, so a
  // pulse appears the cycle after the event that caused it.
  always_comb begin : output_next
    addr_d    = addr;
    wsh_d     = wsh;
    rsh_d     = rsh;
    cnt_d     = cnt;
    is_wr_d   = is_wr;
`ifdef SPI_REG_CTRL_BURST_EN
    burst_d   = burst;
`endif
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_load_d = 1'b0;
    err_d     = 1'b0;
    if (cmd_stb) begin
      addr_d  = ADDR_W'(bus.spi_rx_data[3:0]);
      cnt_d   = '0;
      is_wr_d = bus.spi_rx_data[4];
`ifdef SPI_REG_CTRL_BURST_EN
      burst_d = bus.spi_rx_data[5];
`endif
    end else begin
      case (state)
        S_ADDR:
          if (dat_stb) begin
            addr_d = addr_shift;
            if (cnt == ADDR_LAST) begin
              cnt_d = '0;
              if (!is_wr) begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_shift;
              end
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        S_WDATA:
          if (dat_stb) begin
            wsh_d = data_shift;
            if (cnt == DATA_LAST) begin
              cnt_d     = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = addr;
              wr_data_d = data_shift;
`ifdef SPI_REG_CTRL_BURST_EN
              if (burst) addr_d = addr + ADDR_W'(1);
`endif
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        S_RWAIT:
          // A data strobe before the read returned means the master is
          // already clocking out data we do not have: flag and abandon.
          if (dat_stb) begin
            err_d = 1'b1;
          end else if (bus.reg_rd_valid) begin
            tx_load_d = 1'b1;
            tx_data_d = bus.reg_rd_data[DATA_W-1 -: 8];
            rsh_d     = DATA_W'(bus.reg_rd_data << 8);
            cnt_d     = CNT_W'(1);
          end
        S_RDATA:
          // cnt counts bytes already handed to the shifter; the strobe after
          // the last one closes the word.
          if (dat_stb) begin
            if (cnt == DATA_END) begin
              cnt_d = '0;
`ifdef SPI_REG_CTRL_BURST_EN
              if (burst) begin
                addr_d    = addr + ADDR_W'(1);
                rd_addr_d = addr + ADDR_W'(1);
                rd_en_d   = 1'b1;
              end
`endif
            end else begin
              tx_load_d = 1'b1;
              tx_data_d = rsh[DATA_W-1 -: 8];
              rsh_d     = DATA_W'(rsh << 8);
              cnt_d     = cnt + CNT_W'(1);
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      wsh       <= '0;
      rsh       <= '0;
      cnt       <= '0;
      is_wr     <= 1'b0;
`ifdef SPI_REG_CTRL_BURST_EN
      burst     <= 1'b0;
`endif
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr      <= addr_d;
      wsh       <= wsh_d;
      rsh       <= rsh_d;
      cnt       <= cnt_d;
      is_wr     <= is_wr_d;
`ifdef SPI_REG_CTRL_BURST_EN
      burst     <= burst_d;
`endif
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
    end
  end

  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = wr_data_q;
  assign bus.reg_wr_en    = wr_en_q;
  assign bus.reg_rd_addr  = rd_addr_q;
  assign bus.reg_rd_en    = rd_en_q;
  assign bus.spi_tx_data  = tx_data_q;
  assign bus.spi_tx_load  = tx_load_q;
  assign bus.err_underrun = err_q;
  assign bus.busy         = (state != S_IDLE) && (state != S_DISCARD);
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl (ADDR_BYTES=1, DATA_BYTES=4). Expected strobes
// are queued with the cycle they must appear in and checked by a monitor on
// the falling clock edge; level checks are made directly in the sequence.
module tb_spi_reg_ctrl;
  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

`ifdef SPI_REG_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  spi_reg_ctrl_if #(.ADDR_BYTES(1), .DATA_BYTES(4)) bus ();

  spi_reg_ctrl #(.ADDR_BYTES(1), .DATA_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       q_wr[$], q_rd[$], q_tx[$], q_err[$];
  exp_t       m_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         ncyc  = 0;
  int         e_cyc = 0;
  logic [7:0] last_tx = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input exp_t e, input logic [63:0] obs);
    n_cmp++;
    assert (e.cyc == ncyc && e.val === obs) else begin
      n_err++;
      $error("FAIL %s: observed %h at cycle %0d expected %h at cycle %0d",
             tag, obs, ncyc, e.val, e.cyc);
    end
  endtask

  // Strobe monitor: each pulse must match the head of its queue, both in
  // value and in the cycle it was predicted for.
  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (bus.reg_wr_en) begin
        if (q_wr.size() > 0) m_e = q_wr.pop_front();
        else begin m_e.cyc = -1; m_e.val = '1; end
        chk_ev("reg_wr", m_e, 64'({bus.reg_wr_addr, bus.reg_wr_data}));
      end
      if (bus.reg_rd_en) begin
        if (q_rd.size() > 0) m_e = q_rd.pop_front();
        else begin m_e.cyc = -1; m_e.val = '1; end
        chk_ev("reg_rd", m_e, 64'(bus.reg_rd_addr));
      end
      if (bus.spi_tx_load) begin
        if (q_tx.size() > 0) m_e = q_tx.pop_front();
        else begin m_e.cyc = -1; m_e.val = '1; end
        chk_ev("tx_load", m_e, 64'(bus.spi_tx_data));
      end
      if (bus.err_underrun) begin
        if (q_err.size() > 0) m_e = q_err.pop_front();
        else begin m_e.cyc = -1; m_e.val = '1; end
        chk_ev("underrun", m_e, 64'(bus.err_underrun));
      end
    end
  end

  // One-cycle pulse of rx strobe and/or read-valid; e_cyc is the monitor
  // cycle in which the DUT's response to this edge becomes visible.
  task automatic drive(input bit rxv, input bit first, input logic [7:0] b,
                       input bit rdv, input logic [31:0] rdd);
    @(posedge clk);
    #1;
    bus.spi_rx_valid = rxv;
    bus.spi_rx_first = first;
    bus.spi_rx_data  = b;
    bus.reg_rd_valid = rdv;
    bus.reg_rd_data  = rdd;
    @(posedge clk);
    e_cyc = ncyc + 1;
    #1;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_first = 1'b0;
    bus.reg_rd_valid = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b, input bit first);
    drive(1'b1, first, b, 1'b0, 32'h0);
  endtask

  task automatic rdok(input logic [31:0] d);
    drive(1'b0, 1'b0, 8'h00, 1'b1, d);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    q_wr.push_back('{e_cyc, 64'({a, d})});
  endtask

  task automatic push_rd(input logic [11:0] a);
    q_rd.push_back('{e_cyc, 64'(a)});
  endtask

  task automatic push_tx(input logic [7:0] b);
    q_tx.push_back('{e_cyc, 64'(b)});
    last_tx = b;
  endtask

  task automatic push_err();
    q_err.push_back('{e_cyc, 64'(1)});
  endtask

  // Sends a 32-bit word MSB first; the write strobe is predicted off the
  // last byte.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx(w[31-8*i -: 8], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.spi_rx_data  = 8'h00;
    bus.spi_rx_first = 1'b0;
    bus.spi_rx_valid = 1'b0;
    bus.reg_rd_data  = 32'h0;
    bus.reg_rd_valid = 1'b0;
    idle(3);
    chk("reset_addr_data", 64'({bus.reg_wr_addr, bus.reg_rd_addr, bus.reg_wr_data}), 64'h0);
    chk("reset_strobes", 64'({bus.spi_tx_data, bus.spi_tx_load, bus.reg_wr_en,
                              bus.reg_rd_en, bus.err_underrun, bus.busy}), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Single write to 0xABC
    rx(8'h1A, 1'b1);
    chk("busy_after_cmd", 64'(bus.busy), 64'h1);
    rx(8'hBC, 1'b0);
    send_word(32'hDEADBEEF);
    push_wr(12'hABC, 32'hDEADBEEF);
    idle(2);
    chk("busy_after_write", 64'(bus.busy), 64'h0);

    // Single read from 0xABC, turnaround byte after the data is ready
    rx(8'h0A, 1'b1);
    rx(8'hBC, 1'b0);
    push_rd(12'hABC);
    idle(3);
    rdok(32'h12345678); push_tx(8'h12);
    rx(8'h00, 1'b0);    push_tx(8'h34);
    rx(8'h00, 1'b0);    push_tx(8'h56);
    rx(8'h00, 1'b0);    push_tx(8'h78);
    rx(8'h00, 1'b0);
    chk("busy_after_read", 64'(bus.busy), 64'h0);
    rx(8'h00, 1'b0);

    // Burst write 0xFFF, 0x000 (wrap); invalid op without the burst option
    rx(8'h3F, 1'b1);
    rx(8'hFF, 1'b0);
    send_word(32'h11223344);
    if (BURST) push_wr(12'hFFF, 32'h11223344);
    send_word(32'h55667788);
    if (BURST) push_wr(12'h000, 32'h55667788);
    idle(2);
    chk("busy_burst_write", 64'(bus.busy), 64'(BURST));

    // Burst read 0xFFF then 0x000
    rx(8'h2F, 1'b1);
    rx(8'hFF, 1'b0);
    if (BURST) push_rd(12'hFFF);
    idle(2);
    rdok(32'h01020304); if (BURST) push_tx(8'h01);
    rx(8'h00, 1'b0);    if (BURST) push_tx(8'h02);
    rx(8'h00, 1'b0);    if (BURST) push_tx(8'h03);
    rx(8'h00, 1'b0);    if (BURST) push_tx(8'h04);
    rx(8'h00, 1'b0);    if (BURST) push_rd(12'h000);
    idle(2);
    rdok(32'hA0B0C0D0); if (BURST) push_tx(8'hA0);

    // Underrun: data strobe arrives while the read is still pending
    rx(8'h0A, 1'b1);
    rx(8'h55, 1'b0);
    push_rd(12'hA55);
    idle(2);
    rx(8'h00, 1'b0);
    push_err();
    chk("busy_after_underrun", 64'(bus.busy), 64'h0);
    chk("tx_after_underrun", 64'(bus.spi_tx_data), 64'(last_tx));
    rdok(32'h99999999);
    idle(2);
    chk("tx_after_late_valid", 64'(bus.spi_tx_data), 64'(last_tx));

    // Abort a write after two data bytes with a new read command
    rx(8'h11, 1'b1);
    rx(8'h23, 1'b0);
    rx(8'hAA, 1'b0);
    rx(8'hBB, 1'b0);
    rx(8'h0C, 1'b1);
    rx(8'h01, 1'b0);
    push_rd(12'hC01);
    rdok(32'hCAFEF00D); push_tx(8'hCA);
    rx(8'h00, 1'b0);    push_tx(8'hFE);
    rx(8'h00, 1'b0);    push_tx(8'hF0);
    rx(8'h00, 1'b0);    push_tx(8'h0D);
    rx(8'h00, 1'b0);

    // Command byte coinciding with read-valid: data dropped, write decoded
    rx(8'h00, 1'b1);
    rx(8'h12, 1'b0);
    push_rd(12'h012);
    idle(2);
    drive(1'b1, 1'b1, 8'h11, 1'b1, 32'h77777777);
    rx(8'h34, 1'b0);
    send_word(32'h01020304);
    push_wr(12'h134, 32'h01020304);

    // Asynchronous reset in the middle of a read
    rx(8'h0A, 1'b1);
    rx(8'hBC, 1'b0);
    push_rd(12'hABC);
    rdok(32'h12345678); push_tx(8'h12);
    rx(8'h00, 1'b0);    push_tx(8'h34);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_addr_data", 64'({bus.reg_wr_addr, bus.reg_rd_addr, bus.reg_wr_data}), 64'h0);
    chk("midreset_strobes", 64'({bus.spi_tx_data, bus.spi_tx_load, bus.reg_wr_en,
                                 bus.reg_rd_en, bus.err_underrun, bus.busy}), 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rx(8'h55, 1'b0);
    chk("busy_nonfirst_after_reset", 64'(bus.busy), 64'h0);

    idle(4);
    chk("q_wr_drained", 64'(q_wr.size()), 64'h0);
    chk("q_rd_drained", 64'(q_rd.size()), 64'h0);
    chk("q_tx_drained", 64'(q_tx.size()), 64'h0);
    chk("q_err_drained", 64'(q_err.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI-slave command decoder. Sits between the byte-level SPI shifter (rx byte strobe, tx byte load) and a generic single-outstanding register bus.
- Successor to the fixed SFR/AXI decoder: address and data widths are parametrised.
- Adds a registered read path with a valid handshake, MSB-first tx byte serialisation, underrun detection and optional auto-increment bursts.

Parameters:
- ADDR_BYTES, 1, number of address bytes after the command byte; ADDR_W = 4 + 8*ADDR_BYTES (range 1..3).
- DATA_BYTES, 4, bytes per data word; DATA_W = 8*DATA_BYTES (range 1..8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_rx_data  in  8  received byte.
- spi_rx_first  in  1  byte is first of a chip-select frame; qualified by spi_rx_valid.
- spi_rx_valid  in  1  one-cycle strobe per received byte.
- spi_tx_data  out  8  byte for shifter to send next.
- spi_tx_load  out  1  one-cycle load strobe for spi_tx_data.
- reg_wr_addr  out  ADDR_W  write address.
- reg_wr_data  out  DATA_W  write data.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_addr  out  ADDR_W  read address.
- reg_rd_en  out  1  one-cycle read request.
- reg_rd_data  in  DATA_W  read data; sampled when reg_rd_valid=1.
- reg_rd_valid  in  1  read data valid; at most one outstanding read.
- err_underrun  out  1  one-cycle pulse when a read was not ready in time.
- busy  out  1  high in any state other than S_IDLE/S_DISCARD.

Behaviour:
- Reset: all outputs 0; state S_IDLE; address, shift and byte counters 0.
- Command byte (spi_rx_valid && spi_rx_first): accepted in any state; aborts any operation in progress. No strobe from the aborted operation is issued afterwards.
  - Op = data[7:4]: 0x0 single read, 0x1 single write, 0x2 burst read, 0x3 burst write; any other value goes to S_DISCARD.
  - Address MSBs = data[3:0].
- States: S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DISCARD.
- S_ADDR: shift in ADDR_BYTES bytes, MSB first.
  - After the last byte, a write goes to S_WDATA.
  - A read drives reg_rd_en=1 with reg_rd_addr in the following cycle, then goes to S_RWAIT.
- S_WDATA: shift in DATA_BYTES bytes, MSB first.
  - The cycle after the last byte's strobe: reg_wr_en=1 with reg_wr_addr/reg_wr_data.
  - Single write then goes to S_DISCARD. Burst write increments the address and stays in S_WDATA.
- S_RWAIT: on reg_rd_valid, capture the word.
  - Next cycle: spi_tx_load=1, spi_tx_data = word[DATA_W-1 -: 8]; go to S_RDATA.
  - reg_rd_valid outside S_RWAIT is ignored.
- S_RDATA: each non-first rx strobe loads the next lower byte, one cycle after the strobe.
  - The rx strobe after the last byte was loaded ends the word. Single read then goes to S_DISCARD.
  - Burst read increments the address, issues reg_rd_en one cycle later, and goes to S_RWAIT.
- Frame timing: the master sends one turnaround byte after the address. Read latency must be met before the next rx strobe.
- Underrun: a non-first rx strobe in S_RWAIT pulses err_underrun, discards the pending read (its later valid is ignored) and goes to S_DISCARD. spi_tx_data is left unchanged.
- S_DISCARD: ignores non-first bytes; only a command byte exits it.
- Address increment wraps modulo 2^ADDR_W (e.g. 0xFFF→0x000 for ADDR_BYTES=1).
- Simultaneous command byte and reg_rd_valid: the command wins; the data is dropped.
- Asynchronous reset mid-frame: immediate return to reset values. The next frame must start with spi_rx_first.

Optional Feature:
- Macro: SPI_REG_CTRL_BURST_EN.
- Defined: ops 0x2/0x3 are burst reads/writes as above.
- Undefined: ops 0x2/0x3 decode as invalid and go to S_DISCARD; no increment logic is built.

Test Plan:
- Single write, ADDR_BYTES=1, DATA_BYTES=4: bytes 0x1A,0xBC,0xDE,0xAD,0xBE,0xEF -> one reg_wr_en with addr 0xABC, data 0xDEADBEEF, one cycle after the last strobe.
- Single read: 0x0A,0xBC,dummy; reg_rd_valid after 3 cycles with 0x12345678 -> reg_rd_addr 0xABC; tx loads 0x12, then 0x34, 0x56, 0x78 on the successive rx strobes; then discard.
- Burst write (macro on): 0x3F,0xFF plus 8 data bytes -> writes to 0xFFF then 0x000.
- Burst write (macro off): same bytes -> no reg_wr_en.
- Underrun: read with reg_rd_valid held low past the dummy byte -> err_underrun pulse, no spi_tx_load. Later reg_rd_valid produces no spi_tx_load.
- Abort and reset: new command byte mid-write (after 2 data bytes) -> no reg_wr_en, new op decoded. rst_n low mid-read -> all outputs 0 immediately, busy=0.
